// File: rtl/add_sub_pkg.sv
// Shared types and constants for the sequential add/sub unit.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_sub_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_slice.sv
// One SLICE-bit ripple stage of the add/sub datapath; purely combinational.
module add_sub_slice
    import add_sub_pkg::*;
#(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             m,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] w_bx;
    logic             w_c;

    // Ripple through the slice, capturing the carry entering the top bit for overflow.
    always_comb begin
        w_bx     = b_i ^ {SLICE{m == MODE_SUB}};
        w_c      = cin;
        sum      = {SLICE{1'b0}};
        c_msb_in = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                c_msb_in = w_c;
            end else begin
                c_msb_in = c_msb_in;
            end
            sum[i] = a_i[i] ^ w_bx[i] ^ w_c;
            w_c    = (a_i[i] & w_bx[i]) | (a_i[i] & w_c) | (w_bx[i] & w_c);
        end
        cout = w_c;
    end

endmodule

// File: rtl/seq_add_sub_unit.sv
// Multi-cycle two's-complement adder/subtractor, SLICE bits per clock through a
// registered carry; result and flags are published with a one-cycle done pulse.
module seq_add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH % SLICE) != 0 || WIDTH < 2) begin : g_bad_param
        $error("seq_add_sub_unit: WIDTH must be >= 2 and a multiple of SLICE");
    end

    add_sub_state_t   r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    int               w_lo;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_acc_next;

    // Select the active operand slice and merge its sum into the accumulator image.
    always_comb begin
        w_lo       = int'(r_idx) * SLICE;
        w_a_slice  = r_a[w_lo +: SLICE];
        w_b_slice  = r_b[w_lo +: SLICE];
        w_acc_next = r_acc;
        w_acc_next[w_lo +: SLICE] = w_sum;
    end

    add_sub_slice #(.SLICE(SLICE)) u_slice (
        .a_i      (w_a_slice),
        .b_i      (w_b_slice),
        .m        (r_m),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Control FSM with datapath and output registers; start is only honoured in IDLE and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_m         <= MODE_ADD;
            r_carry     <= 1'b0;
            r_idx       <= {IDX_W{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_m     <= m;
                        r_carry <= m;
                        r_idx   <= {IDX_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_result    <= w_acc_next;
                        r_carry_out <= w_cout;
                        r_overflow  <= w_cout ^ w_c_msb_in;
                        r_zero      <= (w_acc_next == {WIDTH{1'b0}});
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1'b1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
